// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys-1A HI/LO multiply/divide unit:
// operation codes and controller state encoding.
package minisys_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/minisys_div32.sv
// Iterative radix-2 restoring divider on 32-bit magnitudes: one quotient
// bit per step, 32 steps after start. Sign handling lives in the caller.
module minisys_div32 (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic        clear,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last,
    output logic        done
);

    logic [31:0] divisor_q, divisor_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [32:0] shift_s;
    logic        ge_s;

    // Dividend bits shift out of quo_q into the partial remainder while
    // quotient bits shift in from the right.
    always_comb begin
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        shift_s   = {rem_q, quo_q[31]};
        ge_s      = (shift_s >= {1'b0, divisor_q});
        if (clear) begin
            cnt_d  = 6'd0;
            done_d = 1'b0;
        end else if (start) begin
            divisor_d = divisor;
            quo_d     = dividend;
            rem_d     = 32'd0;
            cnt_d     = 6'd0;
            done_d    = 1'b0;
        end else if (step) begin
            // On success the true difference is below the divisor, so the low 32 bits are exact.
            if (ge_s) begin
                rem_d = shift_s[31:0] - divisor_q;
            end else begin
                rem_d = shift_s[31:0];
            end
            quo_d  = {quo_q[30:0], ge_s};
            cnt_d  = cnt_q + 6'd1;
            done_d = (cnt_q == 6'd31);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            divisor_q <= 32'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            cnt_q     <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = step & (cnt_q == 6'd31);
    assign done      = done_q;

endmodule

// File: rtl/minisys_muldiv.sv
// HI/LO multiply/divide unit in the EXE stage: owns HI/LO, runs MULT/MULTU
// in one extra cycle and DIV/DIVU in 33, and requests a stall while busy.
module minisys_muldiv
    import minisys_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi2rdataM,
    output logic [31:0] lo2rdataM
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        mul_signed_q, mul_signed_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        busy_q, busy_d;

    logic        accept_s, signed_op_s, rs_neg_s, rt_neg_s;
    logic [31:0] rs_mag_s, rt_mag_s;
    logic [63:0] mul_a_ext_s, mul_b_ext_s, product_s;
    logic        div_start_s, div_step_s, div_last_s, div_done_s;
    logic [31:0] div_quo_s, div_rem_s;

    assign accept_s    = op_valid & (state_q == ST_IDLE) & ~flush;
    assign signed_op_s = (op_code == OP_MULT) | (op_code == OP_DIV);
    assign rs_neg_s    = signed_op_s & rs_data[31];
    assign rt_neg_s    = signed_op_s & rt_data[31];
    assign rs_mag_s    = rs_neg_s ? (32'd0 - rs_data) : rs_data;
    assign rt_mag_s    = rt_neg_s ? (32'd0 - rt_data) : rt_data;
    assign div_start_s = accept_s & ((op_code == OP_DIV) | (op_code == OP_DIVU));
    assign div_step_s  = (state_q == ST_DIV) & ~flush;

    // Extending to 64 bits makes the truncated product correct for both signednesses.
    assign mul_a_ext_s = {{32{mul_signed_q & mul_a_q[31]}}, mul_a_q};
    assign mul_b_ext_s = {{32{mul_signed_q & mul_b_q[31]}}, mul_b_q};
    assign product_s   = mul_a_ext_s * mul_b_ext_s;

    minisys_div32 u_div (
        .clk       (clk),
        .clrn      (clrn),
        .start     (div_start_s),
        .clear     (flush),
        .step      (div_step_s),
        .dividend  (rs_mag_s),
        .divisor   (rt_mag_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s),
        .last      (div_last_s),
        .done      (div_done_s)
    );

    // Controller next state and HI/LO updates; flush beats accept and completion.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            mul_a_d      = rs_data;
                            mul_b_d      = rt_data;
                            mul_signed_d = signed_op_s;
                            state_d      = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            qneg_d  = rs_neg_s ^ rt_neg_s;
                            rneg_d  = rs_neg_s;
                            state_d = ST_DIV;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    hi_d    = product_s[63:32];
                    lo_d    = product_s[31:0];
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_last_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_done_s) begin
                    lo_d    = qneg_q ? (32'd0 - div_quo_s) : div_quo_s;
                    hi_d    = rneg_q ? (32'd0 - div_rem_s) : div_rem_s;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Architectural HI/LO, operand latches and state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            mul_signed_q <= 1'b0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            busy_q       <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign hi2rdataM = hi_q;
    assign lo2rdataM = lo_q;

endmodule

// File: tb/tb_minisys_muldiv.sv
// Directed bench for minisys_muldiv: a vector table of single operations
// followed by hand sequences for flush, reset and stall corner cases.
module tb_minisys_muldiv;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi2rdataM, lo2rdataM;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[12];

    minisys_muldiv dut (
        .clk       (clk),
        .clrn      (clrn),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .busy      (busy),
        .hi2rdataM (hi2rdataM),
        .lo2rdataM (lo2rdataM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{3'd5, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[2]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1};
        vecs[3]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1};
        vecs[4]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vecs[6]  = '{3'd3, 32'h00000055, 32'h0,        32'h00000055, 32'hFFFFFFFF, 33};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[8]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        vecs[10] = '{3'd6, 32'h11111111, 32'h22222222, 32'hFFFFFFFE, 32'h00000001, 0};
        vecs[11] = '{3'd2, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'h00000001, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi2rdataM, 32'h0);
        check("reset_lo", lo2rdataM, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_idle(cyc);
            check($sformatf("vec%0d_busy_cycles", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), hi2rdataM, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo2rdataM, vecs[i].lo);
        end

        // Flush at cycle 10 of a division: HI/LO keep the previous result.
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_hi", hi2rdataM, 32'hFFFFFFFB);
        check("flush_lo", lo2rdataM, 32'h00000001);

        // Flush while the product stage is pending suppresses the write.
        issue(3'd0, 32'd3, 32'd3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("mulflush_busy", {31'd0, busy}, 32'd0);
        check("mulflush_hi", hi2rdataM, 32'hFFFFFFFB);
        check("mulflush_lo", lo2rdataM, 32'h00000001);

        // Asynchronous reset in the middle of a division.
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi2rdataM, 32'h0);
        check("rst_lo", lo2rdataM, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // MTHI presented while dividing is ignored.
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd4;
        rs_data  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        wait_idle(cyc);
        check("stall_busy_cycles", cyc, 30);
        check("stall_hi", hi2rdataM, 32'h00000002);
        check("stall_lo", lo2rdataM, 32'h0000000E);

        // Flush in the accepting cycle blocks the MTHI.
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 3'd4;
        rs_data  = 32'h12345678;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        check("idleflush_busy", {31'd0, busy}, 32'd0);
        check("idleflush_hi", hi2rdataM, 32'h00000002);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/minisys_muldiv.md
# minisys_muldiv

HI/LO multiply/divide unit of the Minisys-1A pipeline, inside the EXE stage, directly upstream of the MEM stage. Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns the architectural HI and LO registers, and presents them as `hi2rdataM`/`lo2rdataM` to the EXE/MEM boundary for MFHI/MFLO. Multi-cycle operations raise `busy`, which the hazard unit uses to stall IF/ID/EXE.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  EXE holds a HI/LO instruction this cycle.
- `op_code`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- `rs_data`  in  32  forwarded rs operand (multiplicand/dividend/MT source).
- `rt_data`  in  32  forwarded rt operand (multiplier/divisor).
- `flush`  in  1  cancel any in-flight operation.
- `busy`  out  1  stall request; high whenever state ≠ IDLE.
- `hi2rdataM`  out  32  current HI register.
- `lo2rdataM`  out  32  current LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accept: `op_valid & !busy & !flush` at a rising edge. `op_valid` while `busy` is ignored (hazard unit holds the instruction).
- MTHI/MTLO: HI (resp. LO) ← `rs_data` at the accepting edge; state stays IDLE.
- MULT/MULTU: operands captured at accept, state → MUL. MUL is a registered 64-bit product stage (signed for MULT, unsigned for MULTU); at the MUL exit edge {HI,LO} ← product, state → IDLE.
- DIV/DIVU: capture operand magnitudes (signed ops take |rs|, |rt| and remember signs), 6-bit counter ← 0, state → DIV. Radix-2 restoring, one quotient bit per cycle, 32 cycles; then FIX.
- FIX: signed only: quotient negated iff operand signs differ; remainder carries dividend sign. LO ← quotient, HI ← remainder, state → IDLE.
- Divide by zero: no trap; the algorithm runs unmodified: unsigned gives LO = FFFFFFFF, HI = dividend; signed then applies the FIX rules.
- 0x80000000 / FFFFFFFF (DIV): LO = 80000000, HI = 0.
- `flush` while not IDLE: state → IDLE at next edge, HI/LO unchanged, counter cleared.
- Reset: HI = LO = 0, state IDLE, `busy` = 0, counter 0.

## Timing
- Edge E0 accepts. MTHI/MTLO: new value visible on outputs after E0; no stall.
- MULT/MULTU: `busy` high for 1 cycle (E0→E1); HI/LO updated at E1, visible from E1.
- DIV/DIVU: `busy` high for 33 cycles (32 DIV + 1 FIX); HI/LO updated at E33.
- `busy` is a pure function of registered state, never combinational from inputs.
- MFHI/MFLO directly after MTHI/MTLO reads the new value with no bypass (write at E0, read in next EXE cycle).
- `flush` has priority over acceptance and over completion in the same cycle.
- Reset asserted mid-division: immediate return to reset values, no partial HI/LO write.

## Structure
- `minisys_pkg`: op_code localparams (OP_MULT…OP_MTLO), state encoding.
- Sub-module `minisys_div32`: iterative restoring divider (start, divisor/dividend magnitudes, 32-cycle counter, quotient/remainder out, done). Sign handling, multiplier, FSM and HI/LO registers remain in `minisys_muldiv`.

## Test plan
- Reset, then MTHI rs=12345678, next cycle MTLO rs=9ABCDEF0 → outputs 12345678/9ABCDEF0, `busy` never high.
- MULT rs=FFFFFFFE (−2), rt=00000003 → `busy` high 1 cycle; HI=FFFFFFFF, LO=FFFFFFFA. MULTU same operands → HI=00000002, LO=FFFFFFFA.
- DIV rs=FFFFFFF9 (−7), rt=00000002 → `busy` 33 cycles; LO=FFFFFFFD, HI=FFFFFFFF. DIVU 100/7 → LO=0000000E, HI=00000002.
- DIVU rs=00000055, rt=0 → LO=FFFFFFFF, HI=00000055; DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- Start DIV, assert `flush` at cycle 10 → `busy` low next cycle, HI/LO keep prior values; pulse `clrn` low at cycle 5 of another DIV → HI=LO=0, `busy`=0 asynchronously.
- Issue MTHI with `op_valid` while DIV `busy` → ignored; HI after completion equals division remainder.
